// File: rtl/sc_io_input_port.sv
// sc_io_input_port: memory-mapped reader for two raw switch buses.
//   Each bus passes through a 2-flop synchroniser and a debouncer; the
//   accepted (stable) values and per-port change flags are returned to CPU
//   loads through a registered read port.
// Ports:
//   clock        in   1      rising-edge clock
//   resetn       in   1      asynchronous active-low reset
//   in_port0     in   WIDTH  raw asynchronous input bus 0
//   in_port1     in   WIDTH  raw asynchronous input bus 1
//   io_rd        in   1      read strobe, sampled each rising edge
//   addr         in   8      byte address (bits [1:0] ignored)
//   io_read_data out  WIDTH  registered read data, held while io_rd=0
//   rd_valid     out  1      high the cycle after each sampled read
//   changed      out  2      unread new stable value on port 1/0
module sc_io_input_port #(
   parameter int          WIDTH           = 32,
   parameter int          DEBOUNCE_CYCLES = 4,
   parameter logic [7:0]  IN0_ADDR        = 8'hC0,
   parameter logic [7:0]  IN1_ADDR        = 8'hC4,
   parameter logic [7:0]  STAT_ADDR       = 8'hC8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [WIDTH-1:0] in_port0,
   input  logic [WIDTH-1:0] in_port1,
   input  logic             io_rd,
   input  logic [7:0]       addr,
   output logic [WIDTH-1:0] io_read_data,
   output logic             rd_valid,
   output logic [1:0]       changed
);
   localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0][WIDTH-1:0] stable;
   logic [1:0]            upd;
   logic [1:0]            clr;
   logic [7:0]            word_addr;
   logic                  sel0, sel1, sel_stat;
   logic [WIDTH-1:0]      rdata;

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [WIDTH-1:0] raw, s1, s2, cand, stb;
      logic [CW-1:0]    cnt;
      assign raw = (p == 0) ? in_port0 : in_port1;
      // The counter saturates at CNT_MAX, so a candidate that has already
      // been accepted keeps re-matching without wrapping or re-flagging.
      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            cnt  <= '0;
            stb  <= '0;
         end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 != cand) begin
               cand <= s2;
               cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
               cnt <= cnt + 1'b1;
            end else if (stb != cand) begin
               stb <= cand;
            end
         end
      end
      assign upd[p]    = (s2 == cand) && (cnt == CNT_MAX) && (stb != cand);
      assign stable[p] = stb;
   end

   assign word_addr = {addr[7:2], 2'b00};
   assign sel0      = word_addr == IN0_ADDR;
   assign sel1      = word_addr == IN1_ADDR;
   assign sel_stat  = word_addr == STAT_ADDR;
   assign clr       = {io_rd && sel1, io_rd && sel0};

   // Reads see the stable value from before this edge's update.
   always_comb begin
      rdata = sel0     ? stable[0] :
              sel1     ? stable[1] :
              sel_stat ? {{(WIDTH-2){1'b0}}, changed} :
                         '0;
   end

   // A new stable value wins over a clearing read on the same edge.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         changed      <= 2'b00;
         rd_valid     <= 1'b0;
         io_read_data <= '0;
      end else begin
         changed  <= upd | (changed & ~clr);
         rd_valid <= io_rd;
         if (io_rd) io_read_data <= rdata;
      end
   end
endmodule
